// File: rtl/mmap_sram_region.sv
// Single-port SRAM window shared by the fetch (exec) and load/store (rw) channels.
// Round-robin arbitration, byte-lane writes, a write-protected low window and registered faults.
module mmap_sram_region #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned ADDR_W      = 22,
   parameter int unsigned RO_WORDS    = 0,
   parameter bit          EXEC_ENABLE = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              exec_req,
   input  logic [ADDR_W-1:0] exec_addr,
   output logic              exec_ready,
   output logic              exec_valid,
   output logic [31:0]       exec_word,
   output logic              exec_fault,
   input  logic              rw_req,
   input  logic              rw_is_write,
   input  logic [ADDR_W-1:0] rw_addr,
   input  logic [31:0]       rw_wdata,
   input  logic [3:0]        rw_be,
   output logic              rw_ready,
   output logic              rw_valid,
   output logic [31:0]       rw_rdata,
   output logic              rw_fault_read,
   output logic              rw_fault_write,
   output logic              rw_fault_address
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic {GntExec, GntRw} grant_e;

   grant_e last_grant_q, last_grant_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0] exec_addr_ext, rw_addr_ext;
   logic        exec_bad, rw_addr_bad, rw_ro_hit, wr_en;
   logic [IDX_W-1:0] acc_idx;
   logic [31:0] rd_word;

   logic        exec_valid_q, exec_fault_q;
   logic [31:0] exec_word_q;
   logic        rw_valid_q, rw_fault_read_q, rw_fault_write_q, rw_fault_address_q;
   logic [31:0] rw_rdata_q;

   // Full-width compares: out-of-range addresses must never alias into the array.
   assign exec_addr_ext = 32'(exec_addr);
   assign rw_addr_ext   = 32'(rw_addr);
   assign exec_bad      = !EXEC_ENABLE || (exec_addr_ext >= DEPTH_WORDS);
   assign rw_addr_bad   = rw_addr_ext >= DEPTH_WORDS;

   if (RO_WORDS > 0) begin : g_ro
      assign rw_ro_hit = rw_addr_ext < RO_WORDS;
   end else begin : g_no_ro
      assign rw_ro_hit = 1'b0;
   end

   // Grants depend only on the requests and last_grant; reset suppresses both.
   always_comb begin
      exec_ready   = 1'b0;
      rw_ready     = 1'b0;
      last_grant_d = last_grant_q;
      if (!reset) begin
         exec_ready = exec_req && (!rw_req || (last_grant_q == GntRw));
         rw_ready   = rw_req && (!exec_req || (last_grant_q == GntExec));
      end
      if (exec_ready) begin
         last_grant_d = GntExec;
      end else if (rw_ready) begin
         last_grant_d = GntRw;
      end
   end

   always_comb begin
      acc_idx = rw_addr[IDX_W-1:0];
      if (exec_ready) begin
         acc_idx = exec_addr[IDX_W-1:0];
      end
   end

   assign rd_word = mem[acc_idx];
   assign wr_en   = rw_ready && rw_is_write && !rw_addr_bad && !rw_ro_hit;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (rw_be[i]) begin
               mem[acc_idx][8*i +: 8] <= rw_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q       <= GntRw;
         exec_valid_q       <= 1'b0;
         exec_fault_q       <= 1'b0;
         exec_word_q        <= '0;
         rw_valid_q         <= 1'b0;
         rw_rdata_q         <= '0;
         rw_fault_read_q    <= 1'b0;
         rw_fault_write_q   <= 1'b0;
         rw_fault_address_q <= 1'b0;
      end else begin
         last_grant_q       <= last_grant_d;
         exec_valid_q       <= exec_ready;
         exec_fault_q       <= exec_ready && exec_bad;
         exec_word_q        <= (exec_ready && !exec_bad) ? rd_word : '0;
         rw_valid_q         <= rw_ready;
         rw_rdata_q         <= (rw_ready && !rw_is_write && !rw_addr_bad) ? rd_word : '0;
         rw_fault_read_q    <= rw_ready && !rw_is_write && rw_addr_bad;
         rw_fault_write_q   <= rw_ready && rw_is_write && (rw_addr_bad || rw_ro_hit);
         rw_fault_address_q <= rw_ready && rw_addr_bad;
      end
   end

   assign exec_valid       = exec_valid_q;
   assign exec_word        = exec_word_q;
   assign exec_fault       = exec_fault_q;
   assign rw_valid         = rw_valid_q;
   assign rw_rdata         = rw_rdata_q;
   assign rw_fault_read    = rw_fault_read_q;
   assign rw_fault_write   = rw_fault_write_q;
   assign rw_fault_address = rw_fault_address_q;

endmodule

// File: doc/mmap_sram_region.md
# mmap_sram_region

Parametrised single-port SRAM region for the CPU memory map. It serves both the instruction-fetch (exec) channel and the load/store (rw) channel of the memory controller through one backing array. Compared with the fixed word-only region protocol, it adds per-channel ready/valid handshakes, round-robin arbitration between the channels, byte-enable writes, a write-protected low window and registered fault reporting. It sits between the memory controller and one decoded address window.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words implemented; word index 0 to DEPTH_WORDS-1.
- ADDR_W, 22: word-address width, covering byte address bits [23:2].
- RO_WORDS, 0: words [0, RO_WORDS) are read-only; 0 means no protection.
- EXEC_ENABLE, 1: when 0, every exec request faults.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- exec_req  in  1  fetch request; held with exec_addr until exec_ready.
- exec_addr  in  ADDR_W  fetch word address.
- exec_ready  out  1  combinational grant of exec this cycle.
- exec_valid  out  1  one-cycle response pulse.
- exec_word  out  32  fetched word; 0 when the response carries a fault.
- exec_fault  out  1  fault flag, qualified by exec_valid.
- rw_req  in  1  load/store request; held with its fields until rw_ready.
- rw_is_write  in  1  1 = store, 0 = load.
- rw_addr  in  ADDR_W  word address.
- rw_wdata  in  32  store data.
- rw_be  in  4  byte enables; bit i enables byte lane [8i+7:8i].
- rw_ready  out  1  combinational grant of rw this cycle.
- rw_valid  out  1  one-cycle response pulse; also pulses for stores.
- rw_rdata  out  32  load data; 0 on stores and on faults.
- rw_fault_read  out  1  load fault; qualified by rw_valid.
- rw_fault_write  out  1  store to the protected window; qualified by rw_valid.
- rw_fault_address  out  1  address >= DEPTH_WORDS; qualified by rw_valid.

## Operation
- At most one channel is granted per cycle; the backing array performs at most one access per cycle.
- Arbitration:
  - Only one channel requesting: that channel is granted.
  - Both channels requesting: the channel not granted last time wins.
  - A last_grant register updates on every grant. Its reset value is RW, so exec wins the first tie.
- ready:
  - Equals req AND grant.
  - Never asserted without req.
  - Depends only on the two req inputs and last_grant, never on the addresses.
- Accepted exec request: faults if EXEC_ENABLE=0 or exec_addr >= DEPTH_WORDS. A faulting request reads nothing.
- Accepted load:
  - rw_fault_address and rw_fault_read are set when rw_addr >= DEPTH_WORDS.
  - Otherwise the addressed word is returned. rw_be is ignored on loads.
- Accepted store:
  - If rw_addr >= DEPTH_WORDS: rw_fault_address and rw_fault_write are set.
  - Else if rw_addr < RO_WORDS: rw_fault_write only.
  - Else each lane with rw_be[i]=1 is written; other lanes keep their old contents.
  - Faulting stores leave the array unchanged.
  - rw_be=0000 is legal: no write, no fault, a response is still issued.
- An address check uses the full ADDR_W bits; nothing is truncated or wrapped modulo DEPTH_WORDS.
- Array contents are not initialised by reset.

## Timing
- Request accepted at edge N (req and ready high in cycle N-1 … stated precisely: accepted in cycle N) gives valid, data and faults in cycle N+1 for exactly one cycle.
- Latency is 1 cycle. Aggregate throughput is one access per cycle across both channels.
- A channel may issue back-to-back accepted requests, with its valid high on consecutive cycles.
- A store is visible to a load accepted in the following cycle, from either channel.
- Simultaneous requests: the loser sees ready=0 and must hold its request. It is granted in the next cycle if the winner requests again, because last_grant then points to the winner.
- Reset values, forced in the cycle after reset is sampled high:
  - exec_valid, rw_valid = 0.
  - exec_word, rw_rdata = 0.
  - All fault flags = 0.
  - last_grant = RW.
- Reset while ready is high aborts that grant: no write, no response.
- A response due in the cycle after reset is dropped.
- exec_ready and rw_ready are 0 while reset is high.

## Test plan
- Store 0xDEADBEEF at word 5 with be=1111, then a load from word 5: rw_valid one cycle after each accept, rw_rdata=0xDEADBEEF, all faults 0.
- Word 5 holds 0xDEADBEEF; store 0x11223344 to word 5 with be=0101; a following load returns 0xDE22BE44.
- Exec and rw both request from cycle 0 for 4 cycles with reqs kept high: grants alternate exec, rw, exec, rw; each valid appears exactly one cycle after its grant.
- RO_WORDS=16, store to word 3: rw_fault_write=1, rw_fault_address=0. A following load from word 3 returns the prior value.
- DEPTH_WORDS=1024:
  - Load from word 1024: rw_fault_address=1, rw_fault_read=1, rw_rdata=0.
  - Exec from word 0x3FFFFF: exec_fault=1.
- Assert reset in the cycle a store is granted: the array is unchanged, and no valid appears in the two cycles that follow.
